// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl
// Turns two bouncing push-buttons and the VGA vsync into the per-frame
// enable pulse, latched up/down direction levels and vertical step size
// consumed by the paddle widget.
//
// Build option: define PADDLE_ACCEL_EN to build the frame counter that grows
// del_y from BASE_DEL towards MAX_DEL while one direction stays held.
// Without it, del_y is the constant BASE_DEL.
//
// Debounce FSM (one instance per button)
//   state        | meaning
//   RELEASED     | button accepted as up, waiting for a pressed sample
//   PRESS_WAIT   | pressed samples being counted, db still low
//   HELD         | button accepted as down, waiting for a released sample
//   RELEASE_WAIT | released samples being counted, db still high
//
// The debounce timer is a down-counter loaded with DEBOUNCE_CYCLES-1 on
// entry to a wait state; the terminal count is reached on the
// DEBOUNCE_CYCLES-th consecutive stable sample (DEBOUNCE_CYCLES >= 2).

module paddle_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit VSYNC_POL       = 1'b1,
    parameter int BASE_DEL        = 2,
    parameter int MAX_DEL         = 8,
    parameter int ACCEL_FRAMES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       vsync,
    output logic       enable,
    output logic       up,
    output logic       down,
    output logic [4:0] del_y,
    output logic       btn_up_db,
    output logic       btn_down_db
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [4:0]       BASE_Y   = 5'(BASE_DEL);
    localparam logic             VS_ACT   = VSYNC_POL;

    // Reject parameter sets the datapath cannot represent.
    if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        BASE_DEL < 1 || MAX_DEL < BASE_DEL || MAX_DEL > 15 ||
        ACCEL_FRAMES < 1) begin : g_param_check
        $error("paddle_input_ctrl: illegal parameter set");
    end

    // bit 0 = up button, bit 1 = down button
    logic [1:0] btn_raw;
    logic [1:0] btn_s1;
    logic [1:0] btn_s2;
    logic [1:0] btn_db;

    assign btn_raw = {btn_down_raw, btn_up_raw};

    // Two-flop synchronisers for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1 <= 2'b00;
            btn_s2 <= 2'b00;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
        end
    end

    genvar g;
    for (g = 0; g < 2; g++) begin : g_debounce
        db_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             db_q;

        // Debounce FSM: a level change is accepted only after an unbroken
        // run of DEBOUNCE_CYCLES equal samples; any opposite sample aborts.
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= RELEASED;
                cnt   <= '0;
                db_q  <= 1'b0;
            end else begin
                case (state)
                    RELEASED: begin
                        if (btn_s2[g]) begin
                            state <= PRESS_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!btn_s2[g]) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt <= CNT_ONE) begin
                            state <= HELD;
                            cnt   <= '0;
                            db_q  <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!btn_s2[g]) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (btn_s2[g]) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt <= CNT_ONE) begin
                            state <= RELEASED;
                            cnt   <= '0;
                            db_q  <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                        db_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_db[g] = db_q;
    end

    assign btn_up_db   = btn_db[0];
    assign btn_down_db = btn_db[1];

    logic vs_s1;
    logic vs_s2;
    logic vs_prev;
    logic frame_tick;

    // Leading edge of the synchronised vsync at its active polarity.
    assign frame_tick = (vs_s2 == VS_ACT) && (vs_prev != VS_ACT);

    // vsync synchroniser and edge register; flops reset to the inactive
    // level so releasing reset can never look like a leading edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_s1   <= ~VS_ACT;
            vs_s2   <= ~VS_ACT;
            vs_prev <= ~VS_ACT;
            enable  <= 1'b0;
        end else begin
            vs_s1   <= vsync;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
            enable  <= frame_tick;
        end
    end

    logic dir_up;
    logic dir_down;

    // Both held cancels; resolution uses db values from before the tick edge.
    assign dir_up   = btn_db[0] & ~btn_db[1];
    assign dir_down = btn_db[1] & ~btn_db[0];

    // Direction levels latched once per frame, together with enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            up   <= 1'b0;
            down <= 1'b0;
        end else if (frame_tick) begin
            up   <= dir_up;
            down <= dir_down;
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam int             FW       = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [FW-1:0]  FRAME_TC = FW'(ACCEL_FRAMES - 1);
    localparam logic [4:0]     MAX_Y    = 5'(MAX_DEL);

    logic [FW-1:0] frame_cnt;
    logic          dir_same;

    assign dir_same = (dir_up | dir_down) && (dir_up == up) && (dir_down == down);

    // Step size grows by one every ACCEL_FRAMES ticks of an unchanged,
    // non-zero direction; any release, cancel or reversal snaps it back.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            del_y     <= BASE_Y;
        end else if (frame_tick) begin
            if (dir_same) begin
                if (frame_cnt == FRAME_TC) begin
                    frame_cnt <= '0;
                    if (del_y < MAX_Y) begin
                        del_y <= del_y + 5'd1;
                    end
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end else begin
                frame_cnt <= '0;
                del_y     <= BASE_Y;
            end
        end
    end
`else
    assign del_y = BASE_Y;
`endif

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl with a short debounce window
// (DEBOUNCE_CYCLES=4) and BASE_DEL=2, MAX_DEL=4, ACCEL_FRAMES=2.
// Inputs change just after a falling edge; outputs are sampled on falling
// edges, half a cycle after the rising edge that updates them.

module tb_paddle_input_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up_raw;
    logic       btn_down_raw;
    logic       vsync;
    logic       enable;
    logic       up;
    logic       down;
    logic [4:0] del_y;
    logic       btn_up_db;
    logic       btn_down_db;

    int vectors = 0;
    int errors  = 0;

`ifdef PADDLE_ACCEL_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .VSYNC_POL      (1'b1),
        .BASE_DEL       (2),
        .MAX_DEL        (4),
        .ACCEL_FRAMES   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .vsync       (vsync),
        .enable      (enable),
        .up          (up),
        .down        (down),
        .del_y       (del_y),
        .btn_up_db   (btn_up_db),
        .btn_down_db (btn_down_db)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected del_y: the accelerated value in the accel build, else BASE_DEL.
    function automatic logic [7:0] dexp(input int v);
        return ACC ? 8'(v) : 8'd2;
    endfunction

    // One frame: vsync pulse of 6 cycles, enable expected exactly 3 cycles
    // after the raw rising edge, with the new levels visible in that cycle.
    task automatic frame(input string tag, input logic eu, input logic ed, input logic [7:0] edel);
        vsync = 1'b1;
        tick(2);
        check({tag, " enable early"}, 8'(enable), 8'd0);
        tick(1);
        check({tag, " enable"}, 8'(enable), 8'd1);
        check({tag, " up"}, 8'(up), 8'(eu));
        check({tag, " down"}, 8'(down), 8'(ed));
        check({tag, " del_y"}, 8'(del_y), edel);
        tick(1);
        check({tag, " enable width"}, 8'(enable), 8'd0);
        tick(2);
        vsync = 1'b0;
        tick(4);
        check({tag, " up held"}, 8'(up), 8'(eu));
        check({tag, " down held"}, 8'(down), 8'(ed));
    endtask

    initial begin
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        vsync        = 1'b0;
        tick(3);

        // Reset values, and no enable while reset is high even with vsync active.
        check("rst enable", 8'(enable), 8'd0);
        check("rst up", 8'(up), 8'd0);
        check("rst down", 8'(down), 8'd0);
        check("rst del_y", 8'(del_y), 8'd2);
        check("rst up_db", 8'(btn_up_db), 8'd0);
        check("rst down_db", 8'(btn_down_db), 8'd0);
        vsync = 1'b1;
        tick(4);
        check("rst vsync no enable", 8'(enable), 8'd0);
        vsync = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(1);
        check("post-reset enable", 8'(enable), 8'd0);
        tick(3);
        check("post-reset enable later", 8'(enable), 8'd0);

        // Idle frames.
        frame("idle1", 1'b0, 1'b0, 8'd2);
        frame("idle2", 1'b0, 1'b0, 8'd2);

        // Bounce on up, then a clean hold; db rises 6 cycles after final edge.
        btn_up_raw = 1'b1;
        tick(2);
        btn_up_raw = 1'b0;
        tick(2);
        check("bounce db low", 8'(btn_up_db), 8'd0);
        btn_up_raw = 1'b1;
        tick(5);
        check("bounce db not yet", 8'(btn_up_db), 8'd0);
        tick(1);
        check("bounce db rise", 8'(btn_up_db), 8'd1);
        check("midframe up low", 8'(up), 8'd0);
        tick(4);
        check("midframe up still low", 8'(up), 8'd0);
        frame("bounce", 1'b1, 1'b0, dexp(2));

        // Release up.
        btn_up_raw = 1'b0;
        tick(5);
        check("release db not yet", 8'(btn_up_db), 8'd1);
        tick(1);
        check("release db fall", 8'(btn_up_db), 8'd0);
        tick(2);
        frame("release", 1'b0, 1'b0, 8'd2);

        // Glitch on down: 3 cycles is one short of acceptance.
        btn_down_raw = 1'b1;
        tick(3);
        btn_down_raw = 1'b0;
        tick(3);
        check("glitch db", 8'(btn_down_db), 8'd0);
        tick(4);
        check("glitch db later", 8'(btn_down_db), 8'd0);
        frame("glitch1", 1'b0, 1'b0, 8'd2);
        frame("glitch2", 1'b0, 1'b0, 8'd2);
        frame("glitch3", 1'b0, 1'b0, 8'd2);

        // Both held cancels; releasing up gives down only at the next enable.
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        tick(7);
        check("both up_db", 8'(btn_up_db), 8'd1);
        check("both down_db", 8'(btn_down_db), 8'd1);
        frame("both1", 1'b0, 1'b0, 8'd2);
        frame("both2", 1'b0, 1'b0, 8'd2);
        btn_up_raw = 1'b0;
        tick(6);
        check("both release up_db", 8'(btn_up_db), 8'd0);
        check("down not before enable", 8'(down), 8'd0);
        tick(2);
        check("down still not before enable", 8'(down), 8'd0);
        frame("down after cancel", 1'b0, 1'b1, 8'd2);

        // Reverse to up and hold for six frames.
        btn_down_raw = 1'b0;
        btn_up_raw   = 1'b1;
        tick(7);
        check("rev up_db", 8'(btn_up_db), 8'd1);
        check("rev down_db", 8'(btn_down_db), 8'd0);
        frame("accel1", 1'b1, 1'b0, dexp(2));
        frame("accel2", 1'b1, 1'b0, dexp(2));
        frame("accel3", 1'b1, 1'b0, dexp(3));
        frame("accel4", 1'b1, 1'b0, dexp(3));
        frame("accel5", 1'b1, 1'b0, dexp(4));
        frame("accel6", 1'b1, 1'b0, dexp(4));

        // Reversal to down snaps del_y back to base.
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b1;
        tick(7);
        frame("reverse1", 1'b0, 1'b1, 8'd2);
        frame("reverse2", 1'b0, 1'b1, dexp(2));
        frame("reverse3", 1'b0, 1'b1, dexp(3));

        // Reset mid-frame with down held.
        vsync = 1'b1;
        reset = 1'b1;
        tick(1);
        check("midrst enable", 8'(enable), 8'd0);
        check("midrst down", 8'(down), 8'd0);
        check("midrst del_y", 8'(del_y), 8'd2);
        check("midrst down_db", 8'(btn_down_db), 8'd0);
        tick(3);
        check("midrst no enable", 8'(enable), 8'd0);
        vsync = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("midrst release enable", 8'(enable), 8'd0);
        tick(8);
        check("midrst down_db again", 8'(btn_down_db), 8'd1);
        frame("after reset", 1'b0, 1'b1, 8'd2);

        btn_down_raw = 1'b0;
        tick(8);
        frame("final idle", 1'b0, 1'b0, 8'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
